// File: rtl/css_mcu0_dmi_uncore_pkg.sv
// ============================================================================
// Module      : css_mcu0_dmi_uncore_pkg
// Description : Register map, CTRL field positions and FSM states for the
//               MCU0 uncore DMI-to-fabric bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package css_mcu0_dmi_uncore_pkg;

    localparam logic [6:0] c_reg_addr  = 7'h50;
    localparam logic [6:0] c_reg_wdata = 7'h51;
    localparam logic [6:0] c_reg_rdata = 7'h52;
    localparam logic [6:0] c_reg_ctrl  = 7'h53;
    localparam logic [6:0] c_reg_id    = 7'h54;

    // CTRL write fields
    localparam int unsigned c_ctrl_go      = 0;
    localparam int unsigned c_ctrl_write   = 1;
    localparam int unsigned c_ctrl_err_clr = 8;

    // CTRL read fields
    localparam int unsigned c_ctrl_busy = 0;
    localparam int unsigned c_ctrl_last = 1;
    localparam int unsigned c_ctrl_err  = 8;
    localparam int unsigned c_ctrl_tmo  = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/css_mcu0_dmi_uncore_bridge.sv
// ============================================================================
// Module      : css_mcu0_dmi_uncore_bridge
// Description : Uncore DMI register target launching single ready/valid
//               fabric transactions, with sticky error/timeout status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module css_mcu0_dmi_uncore_bridge
    import css_mcu0_dmi_uncore_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ID_VALUE       = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        dmi_uncore_en,
    input  logic        dmi_uncore_wr_en,
    input  logic [6:0]  dmi_uncore_addr,
    input  logic [31:0] dmi_uncore_wdata,
    output logic [31:0] dmi_uncore_rdata,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    input  logic        rsp_err
);

    localparam int unsigned    c_cnt_w    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 r_err;
    logic                 r_tmo;

    logic        w_busy;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_addr;
    logic        w_wr_wdata;
    logic        w_wr_ctrl;
    logic        w_go;
    logic        w_err_clr;
    logic        w_accept;
    logic        w_collide;
    logic        w_rsp_done;
    logic        w_timeout;
    logic        w_err_set;
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_rd_data;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_wr       = dmi_uncore_en & dmi_uncore_wr_en;
    assign w_rd       = dmi_uncore_en & ~dmi_uncore_wr_en;
    assign w_wr_addr  = w_wr & (dmi_uncore_addr == c_reg_addr);
    assign w_wr_wdata = w_wr & (dmi_uncore_addr == c_reg_wdata);
    assign w_wr_ctrl  = w_wr & (dmi_uncore_addr == c_reg_ctrl);
    assign w_go       = w_wr_ctrl & dmi_uncore_wdata[c_ctrl_go];
    assign w_err_clr  = w_wr_ctrl & dmi_uncore_wdata[c_ctrl_err_clr];

    // ERR_CLR takes effect before GO is qualified, so CLR+GO launches from IDLE
    assign w_accept   = w_go & ~w_busy & ~(r_err & ~w_err_clr);
    assign w_collide  = w_busy & (w_wr_addr | w_wr_wdata | w_go);

    // A response in the final count cycle wins over the timeout
    assign w_rsp_done = (r_state == ST_RSP) & rsp_valid;
    assign w_timeout  = (r_state == ST_RSP) & ~rsp_valid & (r_cnt == c_cnt_last);
    assign w_err_set  = w_collide | (w_rsp_done & rsp_err) | w_timeout;

    always_comb begin
        w_ctrl_rd              = 32'd0;
        w_ctrl_rd[c_ctrl_busy] = w_busy;
        w_ctrl_rd[c_ctrl_last] = req_write;
        w_ctrl_rd[c_ctrl_err]  = r_err;
        w_ctrl_rd[c_ctrl_tmo]  = r_tmo;
    end

    always_comb begin
        w_rd_data = 32'd0;
        case (dmi_uncore_addr)
            c_reg_addr:  w_rd_data = r_addr;
            c_reg_wdata: w_rd_data = r_wdata;
            c_reg_rdata: w_rd_data = r_rdata;
            c_reg_ctrl:  w_rd_data = w_ctrl_rd;
            c_reg_id:    w_rd_data = ID_VALUE;
            default:     w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_addr           <= 32'd0;
            r_wdata          <= 32'd0;
            r_err            <= 1'b0;
            r_tmo            <= 1'b0;
            dmi_uncore_rdata <= 32'd0;
        end else begin
            if (w_wr_addr && !w_busy) begin
                r_addr <= dmi_uncore_wdata;
            end
            if (w_wr_wdata && !w_busy) begin
                r_wdata <= dmi_uncore_wdata;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
            if (w_timeout) begin
                r_tmo <= 1'b1;
            end else if (w_err_clr) begin
                r_tmo <= 1'b0;
            end
            if (w_rd) begin
                dmi_uncore_rdata <= w_rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rdata   <= 32'd0;
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= 32'd0;
            req_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_REQ;
                        req_valid <= 1'b1;
                        req_write <= dmi_uncore_wdata[c_ctrl_write];
                        req_addr  <= r_addr;
                        req_wdata <= r_wdata;
                    end
                end
                ST_REQ: begin
                    if (req_ready) begin
                        r_state   <= ST_RSP;
                        req_valid <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                ST_RSP: begin
                    if (rsp_valid) begin
                        r_state <= ST_IDLE;
                        if (!req_write) begin
                            r_rdata <= rsp_rdata;
                        end
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/css_mcu0_dmi_uncore_bridge.md
# css_mcu0_dmi_uncore_bridge

Uncore DMI register target that sits directly downstream of the MCU0 DMI mux on its uncore port, which covers DMI addresses 0x50 and above. It decodes the uncore DMI register aperture and exposes address, write-data, read-data and control/status registers. A write to the control register launches a single transaction on a ready/valid request/response port towards the SoC fabric. Responses, fabric errors and timeouts are captured in DMI-readable status.

## Interface
- `TIMEOUT_CYCLES`, 1024: maximum number of cycles in the response-wait state before abort; must be ≥2.
- `ID_VALUE`, 32'h0000_0001: constant returned by the ID register.

- `clk`  in  1  block clock; all logic is on the rising edge.
- `rst_l`  in  1  reset, asynchronous, active-low.
- `dmi_uncore_en`  in  1  DMI access strobe, one cycle per access.
- `dmi_uncore_wr_en`  in  1  write qualifier; valid with `dmi_uncore_en`.
- `dmi_uncore_addr`  in  7  DMI register address.
- `dmi_uncore_wdata`  in  32  DMI write data.
- `dmi_uncore_rdata`  out  32  registered read data.
- `req_valid`  out  1  fabric request valid.
- `req_ready`  in  1  fabric request accept.
- `req_write`  out  1  1 = write, 0 = read.
- `req_addr`  out  32  fabric byte address.
- `req_wdata`  out  32  fabric write data.
- `rsp_valid`  in  1  single-cycle response strobe.
- `rsp_rdata`  in  32  response read data.
- `rsp_err`  in  1  response error; valid with `rsp_valid`.

## Operation
Register map (all other addresses read 0; writes to them are ignored):
- 0x50 ADDR: RW, 32 bits.
- 0x51 WDATA: RW, 32 bits.
- 0x52 RDATA: RO.
- 0x53 CTRL:
  - Write fields: bit0 GO, bit1 WRITE, bit8 ERR_CLR.
  - Read fields: bit0 BUSY, bit1 last WRITE, bit8 ERR (sticky), bit9 TMO (sticky).
  - All other bits read 0.
- 0x54 ID: RO, returns `ID_VALUE`.

FSM states and transitions:
- IDLE→REQ on an accepted GO.
- REQ→RSP when `req_valid & req_ready`.
- RSP→IDLE on `rsp_valid`, or on timeout.
- BUSY is set whenever the state is not IDLE.

Command acceptance:
- GO is accepted only in IDLE with ERR=0.
- On acceptance, ADDR, WDATA and the WRITE bit are latched onto `req_addr`, `req_wdata` and `req_write`.
- GO while ERR=1 is ignored.

Error handling:
- A write to ADDR, WDATA or CTRL-GO while BUSY is dropped and sets ERR.
- If ERR_CLR and GO arrive in the same write, ERR_CLR is applied first, so GO is accepted when IDLE.
- `rsp_valid` in the RSP state loads RDATA from `rsp_rdata` on reads only; writes do not update RDATA.
- `rsp_err=1` sets ERR.
- Timeout sets both ERR and TMO. ERR_CLR clears both.

Stale traffic: `rsp_valid` seen in IDLE or REQ is ignored.

DMI reads: `dmi_uncore_rdata` is loaded on the edge where `dmi_uncore_en & ~dmi_uncore_wr_en`, using pre-edge register state, and holds its value otherwise.

## Timing
Reset values:
- Outputs: `req_valid`=0, `req_write`=0, `req_addr`=0, `req_wdata`=0, `dmi_uncore_rdata`=0.
- Registers: ADDR=WDATA=RDATA=0, ERR=TMO=0.
- State IDLE, timeout counter 0.

Request handshake:
- A GO write sampled at edge N puts `req_valid`=1 after edge N.
- `req_valid`, `req_addr`, `req_wdata` and `req_write` are held stable until `req_ready` is sampled high, then `req_valid` drops on the next edge.
- REQ never times out.

Timeout:
- The counter clears on entry to RSP and increments every RSP cycle.
- At count `TIMEOUT_CYCLES`-1 with no `rsp_valid`, the FSM goes to IDLE.
- `rsp_valid` in the same cycle as the timeout wins: it is treated as a normal response and TMO is not set.

Status visibility: BUSY reads 0 on the first DMI read issued after the edge that returns the FSM to IDLE.

Reset mid-transaction: `rst_l` low forces IDLE and drops `req_valid` asynchronously; an in-flight response is discarded.

## Structure
- Package `css_mcu0_dmi_uncore_pkg` holds:
  - register address localparams (0x50–0x54);
  - CTRL bit-position localparams;
  - FSM state enum (IDLE, REQ, RSP).
- Single module. The timeout counter is inline; no sub-module.

## Test plan
- Reset: read ID → `ID_VALUE`; read CTRL → 0; `req_valid`=0.
- Fabric read:
  - Stimulus: ADDR=0x1000_0040, CTRL=0x1; `req_ready` after 3 cycles; `rsp_rdata`=0xDEAD_BEEF after 5 cycles.
  - Response: RDATA=0xDEAD_BEEF, CTRL reads 0x0.
- Fabric write:
  - Stimulus: WDATA=0x1234_5678, CTRL=0x3.
  - Response: `req_write`=1 with `req_wdata`=0x1234_5678; after `rsp_valid`, RDATA is unchanged and CTRL reads 0x2.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=16, never assert `rsp_valid`.
  - Response: CTRL reads 0x300 exactly 16 cycles after the handshake; then write CTRL=0x100 → CTRL reads 0x0.
- Busy collision and error gating:
  - Stimulus: write ADDR during REQ.
  - Response: ADDR unchanged and ERR=1; a later GO is ignored until ERR_CLR; `rsp_err`=1 also sets ERR.
- Boundaries:
  - `rsp_valid` coincident with the timeout count → TMO=0.
  - `rst_l` pulse during RSP → `req_valid`=0, CTRL=0.
